// File: rtl/id_stage_if.sv
// Bundle of fetch-side, execute-side, writeback and flush signals around the decode stage.
// The slave modport is the decode stage's view; master is the surrounding pipeline's view.
interface id_stage_if;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic [3:0]  out_alu_op;
  logic [2:0]  out_rd;
  logic        out_wen;
  logic        out_illegal;
  logic        wb_en;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        flush;

  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data, flush,
    output in_ready, out_valid, out_a, out_b, out_alu_op, out_rd, out_wen, out_illegal
  );

  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data, flush,
    input  in_ready, out_valid, out_a, out_b, out_alu_op, out_rd, out_wen, out_illegal
  );
endinterface

// File: rtl/id_stage.sv
// Decode/operand-fetch stage: decodes one instruction per cycle, reads the register file
// with writeback bypass, stalls on scoreboard hazards and holds a single ID/EX entry.
`ifndef ALU_ADD
`define ALU_ADD 4'd0
`define ALU_SUB 4'd1
`define ALU_AND 4'd2
`define ALU_OR  4'd3
`define ALU_XOR 4'd4
`define ALU_SLT 4'd5
`endif

module id_stage #(
  parameter int NREG = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  id_stage_if.slave bus
);
  logic [15:0]     rf_q [NREG];
  logic [15:0]     rf_d [NREG];
  logic [NREG-1:0] busy_q, busy_d, busy_eff;

  logic        out_valid_q, out_valid_d;
  logic [15:0] out_a_q, out_a_d;
  logic [15:0] out_b_q, out_b_d;
  logic [3:0]  out_alu_op_q, out_alu_op_d;
  logic [2:0]  out_rd_q, out_rd_d;
  logic        out_wen_q, out_wen_d;
  logic        out_illegal_q, out_illegal_d;

  logic [3:0]  opc;
  logic [2:0]  rd, rs1, rs2, funct;
  logic [15:0] imm, rs1_val, rs2_val;
  logic        r_legal, is_i, is_nop, illegal, wen, hazard, accept;
  logic [3:0]  alu_op;

  assign opc   = bus.in_instr[15:12];
  assign rd    = bus.in_instr[11:9];
  assign rs1   = bus.in_instr[8:6];
  assign rs2   = bus.in_instr[5:3];
  assign funct = bus.in_instr[2:0];
  assign imm   = {{10{bus.in_instr[5]}}, bus.in_instr[5:0]};

  always_comb begin
    r_legal = (opc == 4'h0) && (funct < 3'd6);
    is_i    = (opc >= 4'h1) && (opc <= 4'h5);
    is_nop  = (opc == 4'hF);
    illegal = !(r_legal || is_i || is_nop);
    wen     = (r_legal || is_i) && (rd != 3'd0);
    alu_op  = `ALU_ADD;
    if (r_legal) begin
      case (funct)
        3'd1:    alu_op = `ALU_SUB;
        3'd2:    alu_op = `ALU_AND;
        3'd3:    alu_op = `ALU_OR;
        3'd4:    alu_op = `ALU_XOR;
        3'd5:    alu_op = `ALU_SLT;
        default: alu_op = `ALU_ADD;
      endcase
    end else if (is_i) begin
      case (opc)
        4'h2:    alu_op = `ALU_AND;
        4'h3:    alu_op = `ALU_OR;
        4'h4:    alu_op = `ALU_XOR;
        4'h5:    alu_op = `ALU_SLT;
        default: alu_op = `ALU_ADD;
      endcase
    end
  end

  // Busy bits as seen after this cycle's writeback clear, so a same-cycle writeback unblocks issue.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      busy_eff[i] = busy_q[i] && !(bus.wb_en && (bus.wb_rd == 3'(i)));
    end
    rs1_val = rf_q[rs1];
    if (bus.wb_en && (bus.wb_rd == rs1)) rs1_val = bus.wb_data;
    if (rs1 == 3'd0) rs1_val = '0;
    rs2_val = rf_q[rs2];
    if (bus.wb_en && (bus.wb_rd == rs2)) rs2_val = bus.wb_data;
    if (rs2 == 3'd0) rs2_val = '0;
    hazard = ((r_legal || is_i) && (rs1 != 3'd0) && busy_eff[rs1]) ||
             (r_legal && (rs2 != 3'd0) && busy_eff[rs2]);
  end

  assign bus.in_ready = !bus.flush && !hazard && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    rf_d          = rf_q;
    busy_d        = busy_eff;
    out_valid_d   = out_valid_q;
    out_a_d       = out_a_q;
    out_b_d       = out_b_q;
    out_alu_op_d  = out_alu_op_q;
    out_rd_d      = out_rd_q;
    out_wen_d     = out_wen_q;
    out_illegal_d = out_illegal_q;
    if (bus.wb_en && (bus.wb_rd != 3'd0)) rf_d[bus.wb_rd] = bus.wb_data;
    if (bus.flush) begin
      busy_d      = '0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      if (wen) busy_d[rd] = 1'b1;
      out_valid_d   = 1'b1;
      out_a_d       = rs1_val;
      out_b_d       = r_legal ? rs2_val : imm;
      out_alu_op_d  = alu_op;
      out_rd_d      = rd;
      out_wen_d     = wen;
      out_illegal_d = illegal;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_q          <= '{default: '0};
      busy_q        <= '0;
      out_valid_q   <= 1'b0;
      out_a_q       <= '0;
      out_b_q       <= '0;
      out_alu_op_q  <= `ALU_ADD;
      out_rd_q      <= '0;
      out_wen_q     <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      rf_q          <= rf_d;
      busy_q        <= busy_d;
      out_valid_q   <= out_valid_d;
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      out_alu_op_q  <= out_alu_op_d;
      out_rd_q      <= out_rd_d;
      out_wen_q     <= out_wen_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_a       = out_a_q;
  assign bus.out_b       = out_b_q;
  assign bus.out_alu_op  = out_alu_op_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.out_wen     = out_wen_q;
  assign bus.out_illegal = out_illegal_q;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios followed by random traffic, all checked
// against a behavioural model of decode, register file, scoreboard and ID/EX entry.
module tb_id_stage;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2,
                         OP_OR  = 4'd3, OP_XOR = 4'd4, OP_SLT = 4'd5;
  localparam int K_R = 0, K_I = 1, K_NOP = 2, K_ILL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_stage_if bus ();

  id_stage #(.NREG(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] m_rf [8];
  logic [7:0]  m_busy;
  logic        m_valid, m_wen, m_ill;
  logic [15:0] m_a, m_b;
  logic [3:0]  m_op;
  logic [2:0]  m_rd;
  int          m_kind;

  task automatic compare(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] encR(int rd, int rs1, int rs2, int fn);
    return {4'h0, 3'(rd), 3'(rs1), 3'(rs2), 3'(fn)};
  endfunction

  function automatic logic [15:0] encI(int opc, int rd, int rs1, int imm);
    return {4'(opc), 3'(rd), 3'(rs1), 6'(imm)};
  endfunction

  // Architectural meaning of each encoding, written as a lookup over the instruction table.
  function automatic void decode(input logic [15:0] ins, output int kind, output logic [3:0] op);
    kind = K_ILL;
    op   = OP_ADD;
    case (ins[15:12])
      4'h0: begin
        kind = (ins[2:0] <= 3'd5) ? K_R : K_ILL;
        case (ins[2:0])
          3'd1: op = OP_SUB;
          3'd2: op = OP_AND;
          3'd3: op = OP_OR;
          3'd4: op = OP_XOR;
          3'd5: op = OP_SLT;
          default: op = OP_ADD;
        endcase
      end
      4'h1: begin kind = K_I; op = OP_ADD; end
      4'h2: begin kind = K_I; op = OP_AND; end
      4'h3: begin kind = K_I; op = OP_OR;  end
      4'h4: begin kind = K_I; op = OP_XOR; end
      4'h5: begin kind = K_I; op = OP_SLT; end
      4'hF: kind = K_NOP;
      default: kind = K_ILL;
    endcase
  endfunction

  function automatic logic [15:0] readModel(input logic [2:0] idx, input logic we,
                                            input logic [2:0] wrd, input logic [15:0] wdat);
    if (idx == 3'd0) return 16'h0000;
    if (we && wrd == idx) return wdat;
    return m_rf[idx];
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
    m_busy = 8'h00;
    m_valid = 1'b0;
  endtask

  task automatic checkOutput();
    compare("out_valid", 16'(bus.out_valid), 16'(m_valid));
    if (m_valid) begin
      compare("out_rd", 16'(bus.out_rd), 16'(m_rd));
      compare("out_wen", 16'(bus.out_wen), 16'(m_wen));
      compare("out_illegal", 16'(bus.out_illegal), 16'(m_ill));
      compare("out_alu_op", 16'(bus.out_alu_op), 16'(m_op));
      if (m_kind == K_R || m_kind == K_I) begin
        compare("out_a", bus.out_a, m_a);
        compare("out_b", bus.out_b, m_b);
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, check in_ready, advance the model, check outputs.
  task automatic applyStimulus(input logic v, input logic [15:0] ins, input logic ordy,
                               input logic we, input logic [2:0] wrd, input logic [15:0] wdat,
                               input logic fl);
    int kind;
    logic [3:0] op;
    logic [7:0] beff;
    logic haz, rdy, acc, nwen;
    logic [2:0] rd, rs1, rs2;
    @(negedge clk);
    bus.in_valid = v;  bus.in_instr = ins; bus.out_ready = ordy;
    bus.wb_en = we;    bus.wb_rd = wrd;    bus.wb_data = wdat; bus.flush = fl;
    #1;
    decode(ins, kind, op);
    rd = ins[11:9]; rs1 = ins[8:6]; rs2 = ins[5:3];
    beff = m_busy;
    if (we) beff[wrd] = 1'b0;
    haz = ((kind == K_R || kind == K_I) && rs1 != 0 && beff[rs1]) ||
          (kind == K_R && rs2 != 0 && beff[rs2]);
    rdy = !fl && !haz && (!m_valid || ordy);
    compare("in_ready", 16'(bus.in_ready), 16'(rdy));
    acc  = v && rdy;
    nwen = (kind == K_R || kind == K_I) && rd != 0;
    if (acc) begin
      m_a    = readModel(rs1, we, wrd, wdat);
      m_b    = (kind == K_R) ? readModel(rs2, we, wrd, wdat) : {{10{ins[5]}}, ins[5:0]};
      m_op   = op;
      m_rd   = rd;
      m_wen  = nwen;
      m_ill  = (kind == K_ILL);
      m_kind = kind;
    end
    if (fl) m_busy = 8'h00;
    else begin
      m_busy = beff;
      if (acc && nwen) m_busy[rd] = 1'b1;
    end
    if (fl) m_valid = 1'b0;
    else if (acc) m_valid = 1'b1;
    else if (ordy) m_valid = 1'b0;
    if (we && wrd != 0) m_rf[wrd] = wdat;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [15:0] ins;
    int r;
    bus.in_valid = 0; bus.in_instr = 0; bus.out_ready = 0;
    bus.wb_en = 0; bus.wb_rd = 0; bus.wb_data = 0; bus.flush = 0;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] checking reset state");
    compare("rst_out_valid", 16'(bus.out_valid), 16'h0);
    compare("rst_out_a", bus.out_a, 16'h0);
    compare("rst_out_b", bus.out_b, 16'h0);
    compare("rst_out_rd", 16'(bus.out_rd), 16'h0);
    compare("rst_out_wen", 16'(bus.out_wen), 16'h0);
    compare("rst_out_illegal", 16'(bus.out_illegal), 16'h0);
    compare("rst_out_alu_op", 16'(bus.out_alu_op), 16'(OP_ADD));
    compare("rst_in_ready", 16'(bus.in_ready), 16'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // R1 = 5 via writeback, then ADDI R2, R1, -3
    applyStimulus(0, 16'h0, 1, 1, 3'd1, 16'h0005, 0);
    applyStimulus(1, encI(1, 2, 1, -3), 1, 0, 0, 0, 0);
    compare("addi_a", bus.out_a, 16'h0005);
    compare("addi_b", bus.out_b, 16'hFFFD);
    compare("addi_op", 16'(bus.out_alu_op), 16'(OP_ADD));
    compare("addi_rd", 16'(bus.out_rd), 16'h2);
    compare("addi_wen", 16'(bus.out_wen), 16'h1);

    // ADD R3,R1,R1 then SUB R4,R3,R1 stalls until R3 writes back
    applyStimulus(1, encR(3, 1, 1, 0), 1, 0, 0, 0, 0);
    repeat (3) applyStimulus(1, encR(4, 3, 1, 1), 1, 0, 0, 0, 0);
    applyStimulus(1, encR(4, 3, 1, 1), 1, 1, 3'd3, 16'h1234, 0);
    compare("raw_bypass_a", bus.out_a, 16'h1234);
    compare("raw_sub_op", 16'(bus.out_alu_op), 16'(OP_SUB));

    // Back-pressure: outputs hold while out_ready is low
    repeat (3) applyStimulus(1, encI(3, 6, 0, 5), 0, 0, 0, 0, 0);
    compare("hold_rd", 16'(bus.out_rd), 16'h4);
    applyStimulus(1, encI(3, 6, 0, 5), 1, 0, 0, 0, 0);
    compare("release_rd", 16'(bus.out_rd), 16'h6);

    // Illegal encodings pass through without touching the scoreboard
    applyStimulus(1, encI(7, 7, 0, 0), 1, 0, 0, 0, 0);
    compare("ill_opc_flag", 16'(bus.out_illegal), 16'h1);
    compare("ill_opc_wen", 16'(bus.out_wen), 16'h0);
    applyStimulus(1, encR(7, 0, 0, 6), 1, 0, 0, 0, 0);
    compare("ill_funct_flag", 16'(bus.out_illegal), 16'h1);
    compare("ill_funct_wen", 16'(bus.out_wen), 16'h0);
    applyStimulus(1, encR(1, 7, 7, 2), 1, 0, 0, 0, 0);

    // Flush clears the scoreboard; dependent accepted right after
    applyStimulus(1, encI(1, 5, 0, 1), 1, 0, 0, 0, 0);
    applyStimulus(1, encR(6, 5, 5, 0), 1, 0, 0, 0, 1);
    compare("flush_valid", 16'(bus.out_valid), 16'h0);
    applyStimulus(1, encR(6, 5, 5, 0), 1, 0, 0, 0, 0);
    compare("post_flush_rd", 16'(bus.out_rd), 16'h6);

    // R0 stays zero under a concurrent writeback to R0
    applyStimulus(1, encR(0, 0, 0, 0), 1, 1, 3'd0, 16'hFFFF, 0);
    compare("r0_a", bus.out_a, 16'h0000);
    compare("r0_b", bus.out_b, 16'h0000);
    compare("r0_wen", 16'(bus.out_wen), 16'h0);

    // Reset in the middle of a stall
    applyStimulus(1, encI(1, 1, 0, 7), 1, 0, 0, 0, 0);
    applyStimulus(1, encR(2, 1, 1, 0), 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    compare("midrst_valid", 16'(bus.out_valid), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
    #1;
    compare("midrst_in_ready", 16'(bus.in_ready), 16'h1);
    applyStimulus(1, encR(2, 1, 1, 0), 1, 0, 0, 0, 0);

    $display("[TB] random phase");
    for (int n = 0; n < 500; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 2)      ins = encR($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 5));
      else if (r <= 6) ins = encI($urandom_range(1, 5), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 63));
      else if (r == 7) ins = {4'hF, 12'($urandom)};
      else if (r == 8) ins = {4'($urandom_range(6, 14)), 12'($urandom)};
      else             ins = encI(1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 63));
      applyStimulus(($urandom_range(0, 9) < 8), ins, ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)), 16'($urandom),
                    ($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
